// File: rtl/mips_param_core.sv
// mips_param_core: parametrised MIPS-subset core with a multi-cycle Stein GCD unit; optional shift-add multiplier under MIPS_PARAM_MUL_EN
module mips_param_core #(
    parameter int DW = 16,
    parameter int NREG = 6,
    parameter logic [NREG*5-1:0] REG_MAP = {5'h11, 5'h12, 5'h08, 5'h17, 5'h1F, 5'h10},
    parameter int NOUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instruction,
    input  logic [5*NOUT-1:0]  output_reg,
    output logic               out_valid,
    output logic               instruction_fail,
    output logic [DW*NOUT-1:0] out_data
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int CW = $clog2(DW) + 1;

`ifdef MIPS_PARAM_MUL_EN
    typedef enum logic [1:0] {IDLE, GCD, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, GCD, DONE} state_t;
`endif
    state_t state, state_n;

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] ga, gb, va, vb, res;
    logic [CW-1:0] cnt;
    logic [IW-1:0] wd;
    logic [IW:0]   rs_l, rt_l, rd_l, dst_l;
    logic [IW:0]   sel_l [NOUT];
    logic          last_fail, sc_valid, accept, bad, is_gcd, is_mul, funct_ok;
    logic [5:0]    op;
    logic [6:0]    funct;
    logic [3:0]    shamt;
    logic [15:0]   imm;
`ifdef MIPS_PARAM_MUL_EN
    logic [DW-1:0] acc, acc_n;
`endif

    // {found, index} of a register address in the map
    function automatic logic [IW:0] lookup(input logic [4:0] a);
        logic [IW:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++)
            if (REG_MAP[5*i +: 5] == a) r = {1'b1, IW'(i)};
        return r;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = sc_valid || (state == DONE);

    // decode, operand read and single-cycle ALU
    always_comb begin
        op       = instruction[31:26];
        funct    = instruction[6:0];
        shamt    = instruction[10:7];
        imm      = instruction[15:0];
        rs_l     = lookup(instruction[25:21]);
        rt_l     = lookup(instruction[20:16]);
        rd_l     = lookup(instruction[15:11]);
        dst_l    = (op == 6'h08) ? rt_l : rd_l;
        va       = regs[rs_l[IW-1:0]];
        vb       = regs[rt_l[IW-1:0]];
        is_gcd   = (op == 6'h00) && (funct == 7'h78);
`ifdef MIPS_PARAM_MUL_EN
        is_mul   = (op == 6'h00) && (funct == 7'h18);
`else
        is_mul   = 1'b0;
`endif
        funct_ok = (op == 6'h08) || ((op == 6'h00) &&
                   ((funct inside {7'h20, 7'h24, 7'h25, 7'h27, 7'h00, 7'h02}) || is_gcd || is_mul));
        bad      = !(rs_l[IW] && rt_l[IW] && dst_l[IW] && funct_ok) ||
                   (is_gcd && (va == '0 || vb == '0));
        res      = (op == 6'h08)    ? va + DW'(imm) :
                   (funct == 7'h20) ? va + vb :
                   (funct == 7'h24) ? va & vb :
                   (funct == 7'h25) ? va | vb :
                   (funct == 7'h27) ? ~(va | vb) :
                   (funct == 7'h00) ? vb << shamt : vb >> shamt;
        accept   = in_valid && in_ready;
    end

`ifdef MIPS_PARAM_MUL_EN
    assign acc_n = acc + (gb[0] ? ga : '0);
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept && !bad && is_gcd) state_n = GCD;
`ifdef MIPS_PARAM_MUL_EN
                if (accept && !bad && is_mul) state_n = MUL;
`endif
            end
            GCD:  if (ga == gb) state_n = DONE;
`ifdef MIPS_PARAM_MUL_EN
            MUL:  if (cnt == CW'(DW - 1)) state_n = DONE;
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // register file, operand capture, GCD/MUL iteration and result strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            for (int k = 0; k < NOUT; k++) sel_l[k] <= '0;
            ga               <= '0;
            gb               <= '0;
            cnt              <= '0;
            wd               <= '0;
            last_fail        <= 1'b0;
            sc_valid         <= 1'b0;
            instruction_fail <= 1'b0;
`ifdef MIPS_PARAM_MUL_EN
            acc              <= '0;
`endif
        end else begin
            sc_valid         <= accept && (bad || (!is_gcd && !is_mul));
            instruction_fail <= accept && bad;
            if (accept) begin
                for (int k = 0; k < NOUT; k++) sel_l[k] <= lookup(output_reg[5*k +: 5]);
                last_fail <= bad;
                wd        <= rd_l[IW-1:0];
                ga        <= va;
                gb        <= vb;
                cnt       <= '0;
`ifdef MIPS_PARAM_MUL_EN
                acc       <= '0;
`endif
                if (!bad && !is_gcd && !is_mul) regs[dst_l[IW-1:0]] <= res;
            end
            if (state == GCD) begin
                if (ga == gb) regs[wd] <= ga << cnt;
                else if (!ga[0] && !gb[0]) begin
                    ga  <= ga >> 1;
                    gb  <= gb >> 1;
                    cnt <= cnt + 1'b1;
                end
                else if (!ga[0]) ga <= ga >> 1;
                else if (!gb[0]) gb <= gb >> 1;
                else if (ga > gb) ga <= ga - gb;
                else gb <= gb - ga;
            end
`ifdef MIPS_PARAM_MUL_EN
            if (state == MUL) begin
                acc <= acc_n;
                ga  <= ga << 1;
                gb  <= gb >> 1;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(DW - 1)) regs[wd] <= acc_n;
            end
`endif
        end
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_out
        assign out_data[DW*k +: DW] = (sel_l[k][IW] && !last_fail) ? regs[sel_l[k][IW-1:0]] : '0;
    end
endmodule

// File: tb/tb_mips_param_core.sv
// tb_mips_param_core: scoreboard bench for mips_param_core (ALU, GCD, failures, reset abort, optional multiply)
module tb_mips_param_core;
    localparam int DW = 16;
    localparam int NOUT = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        instruction = '0;
    logic [5*NOUT-1:0]  output_reg = '0;
    logic               out_valid;
    logic               instruction_fail;
    logic [DW*NOUT-1:0] out_data;

    int total = 0;
    int bad = 0;
    logic [DW-1:0]    m [32];
    logic [DW*NOUT:0] q [$];

    mips_param_core #(.DW(DW), .NOUT(NOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .output_reg(output_reg), .out_valid(out_valid),
        .instruction_fail(instruction_fail), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic bit mapped(input logic [4:0] a);
        return a inside {5'h11, 5'h12, 5'h08, 5'h17, 5'h1F, 5'h10};
    endfunction

    function automatic logic [DW-1:0] gcd_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [3:0] sh, input logic [6:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [5*NOUT-1:0] sel4(input logic [4:0] c3, input logic [4:0] c2,
                                               input logic [4:0] c1, input logic [4:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    // model: updates m, pushes {fail, out_data}, returns latency (0 = variable GCD)
    function automatic int predict(input logic [31:0] ins, input logic [5*NOUT-1:0] sel);
        logic [4:0] rs, rt, rd, dst;
        logic [DW-1:0] a, b, r;
        logic [DW*NOUT-1:0] e;
        bit ok;
        int lat;
        rs = ins[25:21];
        rt = ins[20:16];
        rd = ins[15:11];
        a = m[rs];
        b = m[rt];
        r = '0;
        e = '0;
        lat = 1;
        dst = (ins[31:26] == 6'h08) ? rt : rd;
        ok = mapped(rs) && mapped(rt) && mapped(dst);
        if (ins[31:26] == 6'h08) r = a + ins[15:0];
        else if (ins[31:26] != 6'h00) ok = 0;
        else begin
            case (ins[6:0])
                7'h20: r = a + b;
                7'h24: r = a & b;
                7'h25: r = a | b;
                7'h27: r = ~(a | b);
                7'h00: r = b << ins[10:7];
                7'h02: r = b >> ins[10:7];
                7'h78: begin
                    ok = ok && (a != 0) && (b != 0);
                    r = gcd_ref(a, b);
                    if (ok) lat = 0;
                end
`ifdef MIPS_PARAM_MUL_EN
                7'h18: begin
                    r = a * b;
                    if (ok) lat = DW + 1;
                end
`endif
                default: ok = 0;
            endcase
        end
        if (ok) begin
            m[dst] = r;
            for (int k = 0; k < NOUT; k++)
                e[DW*k +: DW] = mapped(sel[5*k +: 5]) ? m[sel[5*k +: 5]] : '0;
        end
        q.push_back({~ok, e});
        return lat;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [5*NOUT-1:0] sel, input bit keep, input string name);
        int lat, n, maxn;
        logic [DW*NOUT:0] e;
        lat = predict(ins, sel);
        maxn = (lat == 1) ? 1 : (lat == 0) ? 2*DW + 2 : lat;
        instruction = ins;
        output_reg = sel;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 1;
        while (out_valid !== 1'b1 && n < maxn) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s busy_ready: got %b want 0 at cycle %0d", name, in_ready, n);
            end
            in_valid = n[0];
            instruction = i_ins(6'h08, 5'h1F, 5'h11, 16'hFFFF);
            @(negedge clk);
            n++;
        end
        if (!keep || lat != 1) in_valid = 1'b0;
        e = q.pop_front();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: no out_valid within %0d cycles", name, maxn);
        end else if ((lat > 0 && n != lat) || (lat == 0 && (n < 2 || n > 2*DW + 2))) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d (0=2..%0d)", name, n, lat, 2*DW + 2);
        end else begin
            total++;
            if ({instruction_fail, out_data} !== e) begin
                bad++;
                $display("FAIL %s result: got fail=%b data=%h want fail=%b data=%h", name,
                         instruction_fail, out_data, e[DW*NOUT], e[DW*NOUT-1:0]);
            end
        end
        if (lat != 1) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s after_done: got valid=%b ready=%b want valid=0 ready=1", name, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++;
        if (instruction_fail !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b want 0", instruction_fail); end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu;
        issue(i_ins(6'h08, 5'h11, 5'h12, 16'h0005), sel4(5'h00, 5'h00, 5'h00, 5'h12), 1, "addi");
        issue(r_ins(5'h12, 5'h12, 5'h08, 4'd0, 7'h20), sel4(5'h00, 5'h00, 5'h00, 5'h08), 1, "add");
        issue(r_ins(5'h11, 5'h08, 5'h08, 4'd4, 7'h00), sel4(5'h12, 5'h00, 5'h11, 5'h08), 0, "sll");
        issue(r_ins(5'h12, 5'h08, 5'h17, 4'd0, 7'h27), sel4(5'h17, 5'h08, 5'h12, 5'h11), 1, "nor");
        issue(r_ins(5'h11, 5'h17, 5'h17, 4'd8, 7'h02), sel4(5'h00, 5'h00, 5'h00, 5'h17), 1, "srl");
        issue(r_ins(5'h17, 5'h08, 5'h10, 4'd0, 7'h24), sel4(5'h10, 5'h00, 5'h00, 5'h00), 1, "and");
        issue(r_ins(5'h12, 5'h08, 5'h10, 4'd0, 7'h25), sel4(5'h08, 5'h12, 5'h17, 5'h10), 0, "or");
    endtask

    task automatic test_gcd;
        issue(i_ins(6'h08, 5'h1F, 5'h11, 16'd48), sel4(5'h00, 5'h00, 5'h00, 5'h11), 1, "set48");
        issue(i_ins(6'h08, 5'h1F, 5'h12, 16'd18), sel4(5'h00, 5'h00, 5'h00, 5'h12), 0, "set18");
        issue(r_ins(5'h11, 5'h12, 5'h10, 4'd0, 7'h78), sel4(5'h00, 5'h12, 5'h11, 5'h10), 0, "gcd");
        issue(r_ins(5'h11, 5'h11, 5'h17, 4'd0, 7'h78), sel4(5'h00, 5'h00, 5'h11, 5'h17), 0, "gcd_same");
    endtask

    task automatic test_fail;
        issue(r_ins(5'h11, 5'h1F, 5'h10, 4'd0, 7'h78), sel4(5'h00, 5'h00, 5'h00, 5'h10), 0, "gcd_zero");
        issue(r_ins(5'h11, 5'h12, 5'h01, 4'd0, 7'h78), sel4(5'h00, 5'h00, 5'h00, 5'h10), 0, "gcd_bad_rd");
        issue(i_ins(6'h23, 5'h11, 5'h12, 16'h0001), sel4(5'h00, 5'h00, 5'h00, 5'h12), 0, "bad_op");
        issue(r_ins(5'h10, 5'h10, 5'h10, 4'd0, 7'h25), sel4(5'h12, 5'h11, 5'h17, 5'h10), 0, "unchanged");
    endtask

    task automatic test_reset_mid;
        int lat;
        lat = predict(r_ins(5'h11, 5'h12, 5'h10, 4'd0, 7'h78), sel4(5'h00, 5'h00, 5'h00, 5'h10));
        q.delete();
        instruction = r_ins(5'h11, 5'h12, 5'h10, 4'd0, 7'h78);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || lat != 0) begin bad++; $display("FAIL mid_busy: got ready=%b lat=%0d want 0 0", in_ready, lat); end
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m[i] = '0;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || out_data !== '0) begin
                bad++;
                $display("FAIL mid_quiet: got valid=%b data=%h want 0 0", out_valid, out_data);
            end
        end
        issue(r_ins(5'h11, 5'h12, 5'h08, 4'd0, 7'h25), sel4(5'h10, 5'h08, 5'h12, 5'h11), 0, "post_reset");
    endtask

    task automatic test_mul;
        issue(i_ins(6'h08, 5'h1F, 5'h11, 16'd300), sel4(5'h00, 5'h00, 5'h00, 5'h11), 1, "set300a");
        issue(i_ins(6'h08, 5'h1F, 5'h12, 16'd300), sel4(5'h00, 5'h00, 5'h00, 5'h12), 0, "set300b");
        issue(r_ins(5'h11, 5'h12, 5'h08, 4'd0, 7'h18), sel4(5'h00, 5'h12, 5'h11, 5'h08), 0, "mul");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m[i] = '0;
        test_reset;
        test_alu;
        test_gcd;
        test_fail;
        test_reset_mid;
        test_mul;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
